// File: rtl/fwd_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fwd_stall_ctrl : N-port operand forwarding and load-use stall control;      |
// |                  optional counters under FWD_STALL_CNT_EN.                  |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module fwd_stall_ctrl #(
   parameter int DATA_W     = 16,
   parameter int REG_AW     = 4,
   parameter int NUM_RD     = 2,
   parameter int PIPE_DEPTH = 3,
   parameter int LOAD_LAT   = 1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      i_hold,
   input  logic                                      i_flush,
   input  logic                                      i_id_valid,
   input  logic                                      i_id_wrEn,
   input  logic [REG_AW-1:0]                         i_id_wrReg,
   input  logic                                      i_id_isLoad,
   input  logic [NUM_RD-1:0]                         i_id_rdEn,
   input  logic [NUM_RD*REG_AW-1:0]                  i_id_rdReg,
   input  logic [NUM_RD*DATA_W-1:0]                  i_rf_data,
   input  logic [PIPE_DEPTH*DATA_W-1:0]              i_stage_data,
   output logic [NUM_RD*DATA_W-1:0]                  o_fwd_data,
   output logic [NUM_RD*$clog2(PIPE_DEPTH+1)-1:0]    o_fwd_sel,
   output logic                                      o_stall
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]                               o_stall_cnt,
   output logic [31:0]                               o_fwd_cnt
`endif
);

   localparam int c_SEL_W = $clog2(PIPE_DEPTH + 1);

   if (LOAD_LAT < 1 || LOAD_LAT >= PIPE_DEPTH) begin : g_param_check
      $error("fwd_stall_ctrl: LOAD_LAT must satisfy 0 < LOAD_LAT < PIPE_DEPTH");
   end

   logic [PIPE_DEPTH-1:0] r_valid;
   logic [PIPE_DEPTH-1:0] r_wr_en;
   logic [PIPE_DEPTH-1:0] r_is_load;
   logic [REG_AW-1:0]     r_wr_reg [PIPE_DEPTH];
   logic [NUM_RD-1:0]     w_not_ready;

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      o_fwd_sel   = '0;
      o_fwd_data  = i_rf_data;
      w_not_ready = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         for (int s = PIPE_DEPTH - 1; s >= 0; s--) begin
            if (i_id_rdEn[p] && r_valid[s] && r_wr_en[s] &&
                (r_wr_reg[s] == i_id_rdReg[p*REG_AW +: REG_AW])) begin
               o_fwd_sel[p*c_SEL_W +: c_SEL_W] = c_SEL_W'(s + 1);
               o_fwd_data[p*DATA_W +: DATA_W]  = i_stage_data[s*DATA_W +: DATA_W];
               w_not_ready[p]                  = r_is_load[s] && (s < LOAD_LAT);
            end
         end
      end
   end

   assign o_stall = i_id_valid & ~i_flush & (|w_not_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= '0;
         r_wr_en   <= '0;
         r_is_load <= '0;
         for (int s = 0; s < PIPE_DEPTH; s++) begin
            r_wr_reg[s] <= '0;
         end
      end else if (!i_hold) begin
         r_valid[0]   <= i_id_valid & ~o_stall & ~i_flush;
         r_wr_en[0]   <= i_id_wrEn;
         r_is_load[0] <= i_id_isLoad;
         r_wr_reg[0]  <= i_id_wrReg;
         for (int s = 1; s < PIPE_DEPTH; s++) begin
            // A flush squashes the stage-0 instruction as it moves on.
            r_valid[s]   <= (s == 1) ? (r_valid[0] & ~i_flush) : r_valid[s-1];
            r_wr_en[s]   <= r_wr_en[s-1];
            r_is_load[s] <= r_is_load[s-1];
            r_wr_reg[s]  <= r_wr_reg[s-1];
         end
      end
   end

`ifdef FWD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;
   logic        w_any_fwd;

   assign w_any_fwd = |o_fwd_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else if (!i_hold) begin
         if (o_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (w_any_fwd && i_id_valid && !o_stall && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
            r_fwd_cnt <= r_fwd_cnt + 32'd1;
         end
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_fwd_cnt   = r_fwd_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fwd_stall_ctrl : directed vector bench for fwd_stall_ctrl (defaults).    |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_fwd_stall_ctrl;

   localparam int c_NV = 25;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_hold = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_id_valid = 1'b0;
   logic        i_id_wrEn = 1'b0;
   logic [3:0]  i_id_wrReg = '0;
   logic        i_id_isLoad = 1'b0;
   logic [1:0]  i_id_rdEn = '0;
   logic [7:0]  i_id_rdReg = '0;
   logic [31:0] i_rf_data = {16'h5A5A, 16'hA5A5};
   logic [47:0] i_stage_data = '0;
   logic [31:0] o_fwd_data;
   logic [3:0]  o_fwd_sel;
   logic        o_stall;
`ifdef FWD_STALL_CNT_EN
   logic [31:0] o_stall_cnt;
   logic [31:0] o_fwd_cnt;
   logic [31:0] m_stall_cnt = '0;
   logic [31:0] m_fwd_cnt   = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fwd_stall_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .i_hold       (i_hold),
      .i_flush      (i_flush),
      .i_id_valid   (i_id_valid),
      .i_id_wrEn    (i_id_wrEn),
      .i_id_wrReg   (i_id_wrReg),
      .i_id_isLoad  (i_id_isLoad),
      .i_id_rdEn    (i_id_rdEn),
      .i_id_rdReg   (i_id_rdReg),
      .i_rf_data    (i_rf_data),
      .i_stage_data (i_stage_data),
      .o_fwd_data   (o_fwd_data),
      .o_fwd_sel    (o_fwd_sel),
      .o_stall      (o_stall)
`ifdef FWD_STALL_CNT_EN
      ,
      .o_stall_cnt  (o_stall_cnt),
      .o_fwd_cnt    (o_fwd_cnt)
`endif
   );

   typedef struct {
      logic        rst, hold, flush, valid, wen;
      logic [3:0]  wreg;
      logic        ld;
      logic [1:0]  rden;
      logic [3:0]  rr0, rr1;
      logic [15:0] sd0, sd1, sd2;
      logic        estall;
      logic [1:0]  es0, es1;
      logic [15:0] ed0, ed1;
   } vec_t;

   vec_t vecs [c_NV];

   function automatic vec_t mk(input logic r, input logic h, input logic f, input logic v,
                               input logic we, input logic [3:0] wr, input logic ld,
                               input logic [1:0] re, input logic [3:0] a0, input logic [3:0] a1,
                               input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                               input logic es, input logic [1:0] e0, input logic [1:0] e1,
                               input logic [15:0] d0, input logic [15:0] d1);
      vec_t t;
      t.rst = r; t.hold = h; t.flush = f; t.valid = v; t.wen = we; t.wreg = wr; t.ld = ld;
      t.rden = re; t.rr0 = a0; t.rr1 = a1; t.sd0 = s0; t.sd1 = s1; t.sd2 = s2;
      t.estall = es; t.es0 = e0; t.es1 = e1; t.ed0 = d0; t.ed1 = d1;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t t);
      rst          = t.rst;
      i_hold       = t.hold;
      i_flush      = t.flush;
      i_id_valid   = t.valid;
      i_id_wrEn    = t.wen;
      i_id_wrReg   = t.wreg;
      i_id_isLoad  = t.ld;
      i_id_rdEn    = t.rden;
      i_id_rdReg   = {t.rr1, t.rr0};
      i_stage_data = {t.sd2, t.sd1, t.sd0};
   endtask

   initial begin
      //            r  h  f  v  we wr  ld rden   rr0 rr1  sd0       sd1       sd2       st e0 e1 d0        d1
      vecs[0]  = mk(1, 0, 0, 0, 0, 0,  0, 2'b00, 0,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[1]  = mk(0, 0, 0, 1, 1, 3,  0, 2'b00, 0,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[2]  = mk(0, 0, 0, 1, 1, 4,  0, 2'b01, 3,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 1, 0, 16'h1234, 16'h5A5A);
      vecs[3]  = mk(0, 0, 0, 1, 1, 5,  1, 2'b00, 0,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[4]  = mk(0, 0, 0, 1, 1, 6,  0, 2'b11, 5,  6,   16'h1111, 16'hBEEF, 16'h3333, 1, 1, 0, 16'h1111, 16'h5A5A);
      vecs[5]  = mk(0, 0, 0, 1, 1, 6,  0, 2'b11, 5,  6,   16'h1111, 16'hBEEF, 16'h3333, 0, 2, 0, 16'hBEEF, 16'h5A5A);
      vecs[6]  = mk(0, 0, 0, 1, 1, 2,  0, 2'b11, 5,  6,   16'h0AAA, 16'h0BBB, 16'h0CCC, 0, 3, 1, 16'h0CCC, 16'h0AAA);
      vecs[7]  = mk(0, 0, 0, 1, 1, 8,  0, 2'b00, 0,  0,   16'h0AAA, 16'h0BBB, 16'h0CCC, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[8]  = mk(0, 0, 0, 1, 1, 2,  0, 2'b00, 0,  0,   16'h0AAA, 16'h0BBB, 16'h0CCC, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[9]  = mk(0, 0, 0, 1, 1, 7,  1, 2'b11, 2,  9,   16'h0001, 16'h0002, 16'h0003, 0, 1, 0, 16'h0001, 16'h5A5A);
      vecs[10] = mk(0, 0, 1, 1, 1, 10, 0, 2'b11, 7,  2,   16'h0101, 16'h0202, 16'h0303, 0, 1, 2, 16'h0101, 16'h0202);
      vecs[11] = mk(0, 0, 0, 1, 0, 0,  0, 2'b11, 7,  2,   16'h0101, 16'h0202, 16'h0303, 0, 0, 3, 16'hA5A5, 16'h0303);
      vecs[12] = mk(0, 0, 0, 1, 0, 0,  0, 2'b11, 7,  10,  16'h0101, 16'h0202, 16'h0303, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[13] = mk(0, 0, 0, 1, 1, 5,  1, 2'b00, 0,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[14] = mk(0, 1, 0, 1, 0, 0,  0, 2'b01, 5,  0,   16'h1234, 16'hBEEF, 16'h3333, 1, 1, 0, 16'h1234, 16'h5A5A);
      vecs[15] = mk(0, 1, 0, 1, 0, 0,  0, 2'b01, 5,  0,   16'h1234, 16'hBEEF, 16'h3333, 1, 1, 0, 16'h1234, 16'h5A5A);
      vecs[16] = mk(0, 1, 0, 1, 0, 0,  0, 2'b01, 5,  0,   16'h1234, 16'hBEEF, 16'h3333, 1, 1, 0, 16'h1234, 16'h5A5A);
      vecs[17] = mk(0, 0, 0, 1, 0, 0,  0, 2'b01, 5,  0,   16'h1234, 16'hBEEF, 16'h3333, 1, 1, 0, 16'h1234, 16'h5A5A);
      vecs[18] = mk(0, 0, 0, 1, 0, 0,  0, 2'b01, 5,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 2, 0, 16'hBEEF, 16'h5A5A);
      vecs[19] = mk(0, 0, 0, 1, 1, 1,  0, 2'b00, 0,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[20] = mk(0, 0, 0, 1, 1, 2,  0, 2'b00, 0,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[21] = mk(0, 0, 0, 1, 1, 3,  0, 2'b00, 0,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[22] = mk(1, 0, 0, 1, 0, 0,  0, 2'b11, 3,  2,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[23] = mk(0, 0, 0, 1, 1, 4,  1, 2'b01, 3,  0,   16'h1234, 16'hBEEF, 16'h3333, 0, 0, 0, 16'hA5A5, 16'h5A5A);
      vecs[24] = mk(0, 0, 0, 1, 0, 0,  0, 2'b01, 4,  0,   16'h1234, 16'hBEEF, 16'h3333, 1, 1, 0, 16'h1234, 16'h5A5A);

      @(posedge clk);
      #1;
      for (int i = 0; i < c_NV; i++) begin
         apply(vecs[i]);
         #1;
         chk("stall", i, {31'd0, o_stall},      {31'd0, vecs[i].estall});
         chk("sel0",  i, {30'd0, o_fwd_sel[1:0]}, {30'd0, vecs[i].es0});
         chk("sel1",  i, {30'd0, o_fwd_sel[3:2]}, {30'd0, vecs[i].es1});
         chk("data0", i, {16'd0, o_fwd_data[15:0]},  {16'd0, vecs[i].ed0});
         chk("data1", i, {16'd0, o_fwd_data[31:16]}, {16'd0, vecs[i].ed1});
`ifdef FWD_STALL_CNT_EN
         if (vecs[i].rst) begin
            m_stall_cnt = '0;
            m_fwd_cnt   = '0;
         end
         chk("stall_cnt", i, o_stall_cnt, m_stall_cnt);
         chk("fwd_cnt",   i, o_fwd_cnt,   m_fwd_cnt);
         if (!vecs[i].rst && !vecs[i].hold) begin
            if (vecs[i].estall) m_stall_cnt = m_stall_cnt + 1;
            if (vecs[i].valid && !vecs[i].estall && ((vecs[i].es0 != 0) || (vecs[i].es1 != 0)))
               m_fwd_cnt = m_fwd_cnt + 1;
         end
`endif
         @(posedge clk);
         #1;
      end

      // Asynchronous reset pulse entirely between clock edges.
      apply(mk(0, 0, 0, 1, 0, 0, 0, 2'b01, 4, 0, 16'h1234, 16'hBEEF, 16'h3333,
               0, 0, 0, 16'h0, 16'h0));
      #1;
      chk("pre_pulse_sel0",  100, {30'd0, o_fwd_sel[1:0]}, 32'd2);
      chk("pre_pulse_data0", 100, {16'd0, o_fwd_data[15:0]}, 32'h0000_BEEF);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("post_pulse_sel0",  101, {30'd0, o_fwd_sel[1:0]}, 32'd0);
      chk("post_pulse_data0", 101, {16'd0, o_fwd_data[15:0]}, 32'h0000_A5A5);
      chk("post_pulse_stall", 101, {31'd0, o_stall}, 32'd0);
`ifdef FWD_STALL_CNT_EN
      chk("post_pulse_stall_cnt", 101, o_stall_cnt, 32'd0);
      chk("post_pulse_fwd_cnt",   101, o_fwd_cnt,   32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
